// File: rtl/nvram_backup_ctrl_if.sv
// Sector-transfer handshake between the save-RAM backup controller and the
// SD image port of user_io; buf_sec carries the dpram port-B sector bits.
interface nvram_backup_ctrl_if #(
   parameter int SW = 4
);
   logic [31:0]   sd_lba;
   logic          sd_rd;
   logic          sd_wr;
   logic          sd_ack;
   logic [SW-1:0] buf_sec;

   modport master (output sd_lba, sd_rd, sd_wr, buf_sec, input sd_ack);
   modport slave  (input sd_lba, sd_rd, sd_wr, buf_sec, output sd_ack);
endinterface

// File: rtl/nvram_backup_ctrl.sv
// Moves the cartridge save RAM to/from the SD backup image sector by sector:
// load on mount, save on OSD request, abort on ROM download, dirty tracking.
module nvram_backup_ctrl #(
   parameter int SECTORS = 16,
   parameter int SW      = $clog2(SECTORS)
) (
   input  logic                clk_sys,
   input  logic                RESET_n,
   input  logic                img_mounted,
   input  logic [31:0]         img_size,
   input  logic                download,
   input  logic                save_req,
   input  logic                nvram_we,
   nvram_backup_ctrl_if.master sd,
   output logic                bk_ena,
   output logic                bk_busy,
   output logic                bk_reset,
   output logic                dirty
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_SAVE = 1'b1;

   state_t        state_q, state_d;
   logic [SW-1:0] lba_q, lba_d;
   logic [SW-1:0] last_q, last_d;
   logic [SW:0]   nload_q, nload_d;
   logic          rd_q, rd_d, wr_q, wr_d, op_q, op_d;
   logic          ld_pend_q, ld_pend_d, sv_pend_q, sv_pend_d;
   logic          abort_q, abort_d;
   logic          bk_ena_q, bk_ena_d, bk_reset_q, bk_reset_d;
   logic          dirty_q, dirty_d, we_seen_q, we_seen_d;

   // arm_q masks the first cycle after reset so levels already high at
   // release are captured into the edge registers without firing.
   logic arm_q, mnt_q, sav_q, dl_q, ack_q;
   logic mnt_rise, sav_rise, dl_rise, ack_rise, ack_fall;
   logic size_zero, kill;

   assign mnt_rise  = arm_q &  img_mounted & ~mnt_q;
   assign sav_rise  = arm_q &  save_req    & ~sav_q;
   assign dl_rise   = arm_q &  download    & ~dl_q;
   assign ack_rise  = arm_q &  sd.sd_ack   & ~ack_q;
   assign ack_fall  = arm_q & ~sd.sd_ack   &  ack_q;
   assign size_zero = (img_size == 32'd0);
   assign kill      = dl_rise | (mnt_rise & size_zero);

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         arm_q <= 1'b0;
         mnt_q <= 1'b0;
         sav_q <= 1'b0;
         dl_q  <= 1'b0;
         ack_q <= 1'b0;
      end else begin
         arm_q <= 1'b1;
         mnt_q <= img_mounted;
         sav_q <= save_req;
         dl_q  <= download;
         ack_q <= sd.sd_ack;
      end
   end

   // Sector count rounded up, clamped to the image capacity. The 32-bit add
   // wraps for sizes within 511 of 4 GiB, which is accepted.
   logic [31:0] sz_sec;
   logic [SW:0] nload_calc;
   always_comb begin
      sz_sec     = (img_size + 32'd511) >> 9;
      nload_calc = (sz_sec > 32'(SECTORS)) ? (SW+1)'(SECTORS) : sz_sec[SW:0];
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q    <= IDLE;
         lba_q      <= '0;
         last_q     <= '0;
         nload_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         op_q       <= OP_LOAD;
         ld_pend_q  <= 1'b0;
         sv_pend_q  <= 1'b0;
         abort_q    <= 1'b0;
         bk_ena_q   <= 1'b0;
         bk_reset_q <= 1'b0;
         dirty_q    <= 1'b0;
         we_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lba_q      <= lba_d;
         last_q     <= last_d;
         nload_q    <= nload_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         op_q       <= op_d;
         ld_pend_q  <= ld_pend_d;
         sv_pend_q  <= sv_pend_d;
         abort_q    <= abort_d;
         bk_ena_q   <= bk_ena_d;
         bk_reset_q <= bk_reset_d;
         dirty_q    <= dirty_d;
         we_seen_q  <= we_seen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lba_d      = lba_q;
      last_d     = last_q;
      nload_d    = nload_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      op_d       = op_q;
      ld_pend_d  = ld_pend_q;
      sv_pend_d  = sv_pend_q;
      abort_d    = abort_q;
      bk_ena_d   = bk_ena_q;
      bk_reset_d = 1'b0;
      dirty_d    = dirty_q;
      we_seen_d  = we_seen_q;

      // Status events run independently of the transfer state.
      if (sav_rise && bk_ena_q) sv_pend_d = 1'b1;
      if (mnt_rise) begin
         if (size_zero) begin
            bk_ena_d  = 1'b0;
            ld_pend_d = 1'b0;
            sv_pend_d = 1'b0;
         end else begin
            bk_ena_d  = 1'b1;
            ld_pend_d = 1'b1;
            nload_d   = nload_calc;
         end
      end
      if (dl_rise) begin
         bk_ena_d  = 1'b0;
         ld_pend_d = 1'b0;
         sv_pend_d = 1'b0;
         if (state_q != IDLE) abort_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            // A rise on the same edge as the start re-queues the op.
            if (!kill && (ld_pend_q || sv_pend_q)) begin
               lba_d     = '0;
               we_seen_d = 1'b0;
               state_d   = REQ;
               if (ld_pend_q) begin
                  op_d      = OP_LOAD;
                  rd_d      = 1'b1;
                  ld_pend_d = mnt_rise;
                  last_d    = SW'(nload_q - (SW+1)'(1));
               end else begin
                  op_d      = OP_SAVE;
                  wr_d      = 1'b1;
                  sv_pend_d = sav_rise & bk_ena_q;
                  last_d    = '1;
               end
            end
         end
         REQ: begin
            if (ack_rise) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (ack_fall) begin
               if (abort_q) begin
                  abort_d = 1'b0;
                  state_d = IDLE;
               end else if (lba_q == last_q) begin
                  state_d = DONE;
               end else begin
                  lba_d   = lba_q + SW'(1);
                  rd_d    = (op_q == OP_LOAD);
                  wr_d    = (op_q == OP_SAVE);
                  state_d = REQ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            abort_d = 1'b0;
            if (op_q == OP_LOAD) begin
               bk_reset_d = ~(abort_q | dl_rise);
               dirty_d    = 1'b0;
            end else begin
               dirty_d    = we_seen_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // Core writes always win so a save racing a write never loses it.
      if (nvram_we) begin
         dirty_d = 1'b1;
         if (state_q != IDLE) we_seen_d = 1'b1;
      end
   end

   assign sd.sd_lba  = {{(32-SW){1'b0}}, lba_q};
   assign sd.buf_sec = lba_q;
   assign sd.sd_rd   = rd_q;
   assign sd.sd_wr   = wr_q;
   assign bk_ena     = bk_ena_q;
   assign bk_busy    = (state_q != IDLE);
   assign bk_reset   = bk_reset_q;
   assign dirty      = dirty_q;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Directed bench for nvram_backup_ctrl: cycle table for a short load plus
// hand sequences for full loads/saves, abort, mount-while-busy and reset.
module tb_nvram_backup_ctrl;
   localparam int SECTORS = 16;
   localparam int SW      = 4;

   logic        clk_sys     = 1'b0;
   logic        RESET_n     = 1'b1;
   logic        img_mounted = 1'b0;
   logic [31:0] img_size    = 32'd0;
   logic        download    = 1'b0;
   logic        save_req    = 1'b0;
   logic        nvram_we    = 1'b0;
   logic        bk_ena, bk_busy, bk_reset, dirty;

   nvram_backup_ctrl_if #(.SW(SW)) sd_if ();

   nvram_backup_ctrl #(.SECTORS(SECTORS), .SW(SW)) dut (
      .clk_sys     (clk_sys),
      .RESET_n     (RESET_n),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .download    (download),
      .save_req    (save_req),
      .nvram_we    (nvram_we),
      .sd          (sd_if),
      .bk_ena      (bk_ena),
      .bk_busy     (bk_busy),
      .bk_reset    (bk_reset),
      .dirty       (dirty)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;
   int rst_pulses = 0;
   int r0;

   always @(posedge clk_sys) begin
      #1;
      if (bk_reset === 1'b1) rst_pulses++;
   end

   typedef struct {
      logic        mnt;
      logic [31:0] size;
      logic        dl, sv, we, ack;
      logic        rd, wr;
      logic [31:0] lba;
      logic        ena, busy, brst, dty;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic mnt, logic [31:0] size, logic dl, logic sv,
                               logic we, logic ack, logic rd, logic wr,
                               logic [31:0] lba, logic ena, logic busy,
                               logic brst, logic dty);
      vec_t v;
      v.mnt = mnt; v.size = size; v.dl = dl; v.sv = sv; v.we = we; v.ack = ack;
      v.rd = rd; v.wr = wr; v.lba = lba; v.ena = ena; v.busy = busy;
      v.brst = brst; v.dty = dty;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [63:0] outs();
      return 64'({sd_if.sd_rd, sd_if.sd_wr, bk_ena, bk_busy, bk_reset, dirty, sd_if.sd_lba});
   endfunction

   task automatic wait_req(input string nm);
      int c = 0;
      while (!(sd_if.sd_rd || sd_if.sd_wr) && c < 60) begin
         tick(1);
         c++;
      end
      chk({nm, "_req"}, 64'(sd_if.sd_rd | sd_if.sd_wr), 64'd1);
   endtask

   // Host side of one sector: check request, ack, check drop, release ack.
   task automatic serve(input logic w, input int l, input string nm);
      wait_req(nm);
      chk({nm, "_op"},  64'({sd_if.sd_rd, sd_if.sd_wr}), w ? 64'd1 : 64'd2);
      chk({nm, "_lba"}, 64'(sd_if.sd_lba), 64'(l));
      sd_if.sd_ack = 1'b1;
      tick(1);
      chk({nm, "_drop"}, 64'({sd_if.sd_rd, sd_if.sd_wr}), 64'd0);
      tick(1);
      sd_if.sd_ack = 1'b0;
      tick(1);
   endtask

   task automatic run(input logic w, input int first, input int last, input string pfx);
      for (int l = first; l <= last; l++) serve(w, l, $sformatf("%s%0d", pfx, l));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1);
   end

   initial begin
      sd_if.sd_ack = 1'b0;
      //                mnt size  dl sv we ack  rd wr lba ena busy brst dty
      tbl[0]  = mk(1, 1000, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(1, 1000, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0);
      tbl[2]  = mk(1, 1000, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0);
      tbl[3]  = mk(1, 1000, 0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0);
      tbl[4]  = mk(1, 1000, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0);
      tbl[5]  = mk(1, 1000, 0, 0, 0, 1,  0, 0, 1, 1, 1, 0, 0);
      tbl[6]  = mk(1, 1000, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0);
      tbl[7]  = mk(1, 1000, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0);
      tbl[8]  = mk(1, 1000, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0);
      tbl[9]  = mk(0, 1000, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0);
      tbl[10] = mk(1, 0,    0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
      tbl[11] = mk(1, 0,    0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
      tbl[12] = mk(1, 0,    0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 1);
      tbl[13] = mk(1, 0,    0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 1);
      tbl[14] = mk(1, 0,    0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 1);
      tbl[15] = mk(1, 0,    0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1);

      // Reset state, and a mount level high across reset release.
      #1 RESET_n = 1'b0;
      #1 chk("reset_outs", outs(), 64'd0);
      img_mounted = 1'b1;
      img_size    = 32'd4096;
      tick(2);
      RESET_n = 1'b1;
      tick(4);
      chk("no_edge_at_release", outs(), 64'd0);
      img_mounted = 1'b0;
      tick(2);

      for (int i = 0; i < 16; i++) begin
         img_mounted  = tbl[i].mnt;
         img_size     = tbl[i].size;
         download     = tbl[i].dl;
         save_req     = tbl[i].sv;
         nvram_we     = tbl[i].we;
         sd_if.sd_ack = tbl[i].ack;
         tick(1);
         chk($sformatf("vec%0d", i), outs(),
             64'({tbl[i].rd, tbl[i].wr, tbl[i].ena, tbl[i].busy, tbl[i].brst,
                  tbl[i].dty, tbl[i].lba}));
      end

      // Full 16-sector load of an 8 KiB image.
      img_mounted = 1'b0;
      tick(1);
      r0 = rst_pulses;
      img_size    = 32'd8192;
      img_mounted = 1'b1;
      run(1'b0, 0, 15, "ldA");
      tick(3);
      chk("ldA_bk_reset_once", 64'(rst_pulses - r0), 64'd1);
      chk("ldA_status", 64'({bk_ena, bk_busy, dirty}), 64'b100);

      // Save after a core write: dirty clears at DONE.
      nvram_we = 1'b1; tick(1); nvram_we = 1'b0; tick(1);
      chk("dirty_set", 64'(dirty), 64'd1);
      save_req = 1'b1;
      run(1'b1, 0, 15, "sv1_");
      tick(3);
      chk("sv1_dirty_clr", 64'({dirty, bk_busy}), 64'd0);
      save_req = 1'b0;
      tick(1);

      // Save with two further rises queued and a write at sector 7.
      save_req = 1'b1;
      run(1'b1, 0, 3, "sv2_");
      save_req = 1'b0; tick(1); save_req = 1'b1; tick(1);
      save_req = 1'b0; tick(1); save_req = 1'b1; tick(1);
      save_req = 1'b0;
      run(1'b1, 4, 6, "sv2_");
      nvram_we = 1'b1; tick(1); nvram_we = 1'b0;
      run(1'b1, 7, 15, "sv2_");
      tick(3);
      chk("sv2_dirty_kept", 64'(dirty), 64'd1);
      run(1'b1, 0, 15, "sv3_");
      tick(3);
      chk("sv3_dirty_clr", 64'(dirty), 64'd0);
      tick(20);
      chk("sv_only_one_more", 64'({bk_busy, sd_if.sd_wr}), 64'd0);

      // Download rise while sector 5 of a load is still requested.
      img_mounted = 1'b0;
      tick(1);
      img_mounted = 1'b1;
      r0 = rst_pulses;
      run(1'b0, 0, 4, "ldC");
      wait_req("dl5");
      download = 1'b1;
      tick(3);
      chk("dl_req_held", 64'({sd_if.sd_rd, bk_busy, sd_if.sd_lba}), 64'({2'b11, 32'd5}));
      sd_if.sd_ack = 1'b1;
      tick(1);
      chk("dl_ack_drop", 64'({sd_if.sd_rd, bk_busy}), 64'b01);
      tick(1);
      sd_if.sd_ack = 1'b0;
      tick(2);
      chk("dl_idle", outs(), 64'(32'd5));
      chk("dl_no_bk_reset", 64'(rst_pulses - r0), 64'd0);
      tick(10);
      chk("dl_no_more", 64'({sd_if.sd_rd, bk_busy}), 64'd0);
      download = 1'b0;
      tick(1);

      // Oversized image clamps to 16 sectors; mount at sector 9 of a save.
      img_mounted = 1'b0;
      tick(1);
      img_size    = 32'd1000000;
      img_mounted = 1'b1;
      r0 = rst_pulses;
      run(1'b0, 0, 15, "ldD");
      tick(3);
      chk("ldD_bk_reset_once", 64'(rst_pulses - r0), 64'd1);
      save_req = 1'b1;
      run(1'b1, 0, 8, "svD");
      img_mounted = 1'b0; tick(1); img_mounted = 1'b1; tick(1);
      run(1'b1, 9, 15, "svD");
      run(1'b0, 0, 15, "ldE");
      tick(3);
      chk("ldE_bk_reset_once", 64'(rst_pulses - r0), 64'd2);
      chk("ldE_idle", 64'(bk_busy), 64'd0);
      save_req = 1'b0;
      tick(1);

      // Asynchronous reset mid-transfer.
      nvram_we = 1'b1; tick(1); nvram_we = 1'b0;
      save_req = 1'b1;
      wait_req("rst");
      chk("pre_rst_active", 64'({sd_if.sd_wr, bk_ena, bk_busy, dirty}), 64'hF);
      #2 RESET_n = 1'b0;
      #1 chk("async_reset", outs(), 64'd0);
      tick(2);
      RESET_n = 1'b1;
      tick(4);
      chk("post_reset_idle", outs(), 64'd0);
      save_req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nvram_backup_ctrl.md
Name: nvram_backup_ctrl

Overview:
Sequences sector transfers between the SD image interface of user_io and the port-B side of the cartridge save-RAM dpram. It handles load-on-mount, save-on-request and abort on ROM download. It also tracks RAM dirtiness, and pulses a core reset after a successful load. It sits between user_io (sd_* signals), the OSD status bits and the nvram dpram.

Parameters:
SECTORS, 16, number of 512-byte sectors in the backup image (power of two, 2..64)
SW, $clog2(SECTORS), width of the sector index

Ports:
clk_sys  in  1  system clock
RESET_n  in  1  asynchronous active-low reset
img_mounted  in  1  level from user_io; rising edge = new image mounted
img_size  in  32  image size in bytes, valid when img_mounted rises
download  in  1  ioctl_download level
save_req  in  1  OSD "Write Save RAM" level; rising edge = save request
nvram_we  in  1  core write strobe to save RAM (sets dirty)
sd_ack  in  1  user_io sector-transfer acknowledge
sd_lba  out  32  sector number to transfer
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
buf_sec  out  SW  sector index for dpram port-B address high bits (= sd_lba[SW-1:0])
bk_ena  out  1  valid backup image present
bk_busy  out  1  transfer in progress
bk_reset  out  1  one-cycle pulse after a completed load
dirty  out  1  save RAM modified since last load/save

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags 0; edge-detect registers 0, so a level already high at reset release does not count as an edge.
- Edges are detected on registered copies of img_mounted, save_req, download and sd_ack.
- Mount rise with img_size != 0:
  - bk_ena <= 1.
  - Set load_pending.
  - Compute nload = min(SECTORS, ceil(img_size/512)) using a 32-bit add of 511, then >>9, then a clamp.
- Mount rise with img_size == 0: bk_ena <= 0; clear pending flags.
- Download rise:
  - bk_ena <= 0; clear pending flags.
  - If not IDLE, set abort.
- Save rise while bk_ena = 1: set save_pending. Only one is held; further rises while it is pending are ignored.
- nvram_we = 1 sets dirty on the same edge.
- States:
  - IDLE:
    - load_pending has priority over save_pending.
    - Start = sd_lba <= 0, clear the chosen pending flag, op <= load/save.
    - A load asserts sd_rd; a save asserts sd_wr. → REQ.
  - REQ: on the sd_ack rising edge, sd_rd/sd_wr <= 0. → XFER.
  - XFER: on the sd_ack falling edge:
    - If abort: clear abort. → IDLE, no bk_reset.
    - Else if sd_lba == last (nload-1 for load, SECTORS-1 for save): → DONE.
    - Else: sd_lba+1, reassert the same request. → REQ.
  - DONE (1 cycle):
    - Load: bk_reset <= 1 for exactly one cycle; dirty <= 0.
    - Save: dirty <= 0 unless nvram_we was seen during the save, in which case dirty stays 1.
    - → IDLE.
- bk_busy = (state != IDLE).
- Request latency: sd_rd/sd_wr assert 2 cycles after the triggering input edge (1 cycle edge register, 1 cycle IDLE decision).
- An abort arriving in REQ does not drop the request. The current sector handshake completes (ack rise, then fall) before returning to IDLE, so the SD protocol is never violated.
- Mount rise while busy: the current operation finishes normally; the new load runs afterwards. A load completes with bk_reset even if the save that preceded it was the running op.
- A save rise coinciding with the last ack fall is latched into save_pending and runs after DONE.
- sd_lba upper bits beyond SW are always 0.
- Reset mid-operation: returns to IDLE immediately and deasserts sd_rd/sd_wr, with no handshake completion. The host is reset together with the core.

Test Plan:
- Mount img_size=8192, SECTORS=16 → sd_rd pulses for LBA 0..15, each dropped on ack rise; after the 16th ack fall, a single-cycle bk_reset; bk_ena=1, dirty=0.
- Mount img_size=1000 → only LBA 0,1 read (nload=2); bk_reset once. Mount img_size=0 → bk_ena=0 and no sd_rd.
- bk_ena=1, nvram_we pulse → dirty=1; save_req rise → sd_wr for LBA 0..15; dirty=0 after DONE. nvram_we again at sector 7 → dirty stays 1 after DONE.
- save_req rise with bk_ena=0 → no sd_wr, bk_busy stays 0. Two save rises during a running save → exactly one further 16-sector save.
- download rise during sector 5 of a load, ack still pending → sd_lba stays 5 until ack falls, then IDLE; bk_reset never asserts; bk_ena=0.
- Mount rise during a save at LBA 9 → save finishes at LBA 15, then load starts at LBA 0; RESET_n low mid-transfer → all outputs 0 asynchronously.
